// File: rtl/menu_select_fsm_if.sv
// menu_select_fsm_if: button inputs and menu status outputs of the song-select menu.
// Ports (signals, named from the FSM's point of view):
//   i_up, i_down, i_enter, i_back, i_done : level button / game-status inputs
//   o_menu_state : 00 MENU, 01 LAUNCH, 10 IN_GAME
//   o_cursor     : highlighted song index
//   o_song       : song latched at selection
//   o_start_pulse: one-cycle game-reset strobe
//   o_in_game    : high while in IN_GAME
interface menu_select_fsm_if #(
    parameter int SONG_W = 2
);
    logic              i_up;
    logic              i_down;
    logic              i_enter;
    logic              i_back;
    logic              i_done;
    logic [1:0]        o_menu_state;
    logic [SONG_W-1:0] o_cursor;
    logic [SONG_W-1:0] o_song;
    logic              o_start_pulse;
    logic              o_in_game;
    modport master (
        output i_up, i_down, i_enter, i_back, i_done,
        input  o_menu_state, o_cursor, o_song, o_start_pulse, o_in_game
    );
    modport slave (
        input  i_up, i_down, i_enter, i_back, i_done,
        output o_menu_state, o_cursor, o_song, o_start_pulse, o_in_game
    );
endinterface

// File: rtl/menu_select_fsm.sv
// menu_select_fsm: song-select menu with cursor, launch strobe and in-game tracking.
// Ports:
//   clk       : sole clock, rising edge
//   i_reset_n : synchronous active-low reset
//   bus       : menu_select_fsm_if.slave (buttons in, state/cursor/song/strobe out)
module menu_select_fsm #(
    parameter int NUM_SONGS    = 3,
    parameter int SONG_W       = 2,
    parameter int WRAP         = 0,
    parameter int REPEAT_TICKS = 0
) (
    input logic              clk,
    input logic              i_reset_n,
    menu_select_fsm_if.slave bus
);
    localparam int CW = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;
    localparam bit REP_EN = (REPEAT_TICKS > 0);
    localparam logic [SONG_W-1:0] LAST = SONG_W'(NUM_SONGS - 1);

    typedef enum logic [1:0] {
        MENU    = 2'b00,
        LAUNCH  = 2'b01,
        IN_GAME = 2'b10
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [SONG_W-1:0] r_cursor, w_cursor_nxt;
    logic [SONG_W-1:0] r_song, w_song_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt, w_cnt_inc;
    logic              r_arm, w_arm_nxt;
    logic              r_up_q, r_down_q, r_enter_q;
    logic              w_up_press, w_dn_press, w_enter_press;
    logic              w_one, w_press_one, w_rep, w_fire;

    assign w_up_press    = bus.i_up & ~r_up_q;
    assign w_dn_press    = bus.i_down & ~r_down_q;
    assign w_enter_press = bus.i_enter & ~r_enter_q;
    assign w_one         = bus.i_up ^ bus.i_down;
    // a fresh press of the only button held; simultaneous up/down never steps
    assign w_press_one   = (w_up_press & ~bus.i_down) | (w_dn_press & ~bus.i_up);
    assign w_cnt_inc     = r_cnt + CW'(1);
    // auto-repeat only continues a hold that began with a real press (r_arm),
    // so buttons carried through reset or a game return never repeat
    assign w_rep         = REP_EN && r_arm && w_one && !w_press_one && (w_cnt_inc == CW'(REPEAT_TICKS));
    assign w_fire        = w_press_one | w_rep;

    always_comb begin
        w_state_nxt  = r_state;
        w_cursor_nxt = r_cursor;
        w_song_nxt   = r_song;
        w_cnt_nxt    = '0;
        w_arm_nxt    = 1'b0;
        case (r_state)
            MENU: begin
                if (w_enter_press) begin
                    w_state_nxt = LAUNCH;
                    w_song_nxt  = r_cursor;
                end else begin
                    if (w_fire && bus.i_up)
                        w_cursor_nxt = (r_cursor == '0) ? ((WRAP != 0) ? LAST : '0) : r_cursor - SONG_W'(1);
                    if (w_fire && bus.i_down)
                        w_cursor_nxt = (r_cursor == LAST) ? ((WRAP != 0) ? '0 : LAST) : r_cursor + SONG_W'(1);
                    if (REP_EN && w_one && (w_press_one || r_arm)) begin
                        w_arm_nxt = 1'b1;
                        w_cnt_nxt = w_fire ? '0 : w_cnt_inc;
                    end
                end
            end
            LAUNCH:  w_state_nxt = IN_GAME;
            IN_GAME: w_state_nxt = (bus.i_done || bus.i_back) ? MENU : IN_GAME;
            default: w_state_nxt = MENU;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            r_state   <= MENU;
            r_cursor  <= '0;
            r_song    <= '0;
            r_cnt     <= '0;
            r_arm     <= 1'b0;
            r_up_q    <= 1'b1;
            r_down_q  <= 1'b1;
            r_enter_q <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cursor  <= w_cursor_nxt;
            r_song    <= w_song_nxt;
            r_cnt     <= w_cnt_nxt;
            r_arm     <= w_arm_nxt;
            r_up_q    <= bus.i_up;
            r_down_q  <= bus.i_down;
            r_enter_q <= bus.i_enter;
        end
    end

    assign bus.o_menu_state  = r_state;
    assign bus.o_cursor      = r_cursor;
    assign bus.o_song        = r_song;
    assign bus.o_start_pulse = (r_state == LAUNCH);
    assign bus.o_in_game     = (r_state == IN_GAME);
endmodule
